// File: rtl/iicmb_cmd_sequencer.sv
// Byte-level I2C transaction sequencer driving an IICMB controller over Wishbone.
// Each phase walks a short step list of WB writes, irq waits and WB reads.
module iicmb_cmd_sequencer #(
  parameter logic [7:0]  BUS_ID      = 8'd0,
  parameter int unsigned IRQ_TIMEOUT = 65535
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_rnw_i,
  input  logic [6:0] req_addr_i,
  input  logic [5:0] req_len_i,
  input  logic       wdata_valid_i,
  output logic       wdata_ready_o,
  input  logic [7:0] wdata_i,
  output logic       rdata_valid_o,
  output logic [7:0] rdata_o,
  output logic       done_o,
  output logic [1:0] status_o,
  output logic       busy_o,
  output logic       cyc_o,
  output logic       stb_o,
  output logic       we_o,
  output logic [1:0] adr_o,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_i,
  input  logic       ack_i,
  input  logic       irq_i
);
  localparam int TW = (IRQ_TIMEOUT > 1) ? $clog2(IRQ_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(IRQ_TIMEOUT - 1);

  localparam logic [1:0] ADR_CSR = 2'd0, ADR_DPR = 2'd1, ADR_CMDR = 2'd2;
  localparam logic [7:0] C_WRITE = 8'h01, C_RDACK = 8'h02, C_RDNAK = 8'h03,
                         C_START = 8'h04, C_STOP  = 8'h05, C_SETBUS = 8'h06;
  localparam logic [1:0] ST_OK = 2'b00, ST_NAK = 2'b01, ST_ERR = 2'b10, ST_TMO = 2'b11;

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_START, S_ADDR, S_WDATA, S_RDATA, S_STOP, S_DONE, S_WB_ACC, S_IRQ_WAIT
  } state_t;
  typedef enum logic [1:0] {A_NONE, A_WR, A_RD, A_IRQ} act_t;

  state_t          r_state, r_ret, w_state, w_ret;
  logic [2:0]      r_step, w_step;
  logic            r_cyc, r_we, w_cyc, w_we;
  logic [1:0]      r_adr, w_adr;
  logic [7:0]      r_dat, w_dat;
  logic [TW-1:0]   r_tmo, w_tmo;
  logic [5:0]      r_cnt, w_cnt;
  logic            r_rnw, w_rnw;
  logic [6:0]      r_addr, w_addr;
  logic [2:0]      r_sts, w_sts;      // {NAK, AL, ERR} from last CMDR read
  logic [1:0]      r_pstat, w_pstat;
  logic            r_reinit, w_reinit;
  logic            r_done, w_done;
  logic [1:0]      r_status, w_status;
  logic            r_rvalid, w_rvalid;
  logic [7:0]      r_rdata, w_rdata;
  logic            w_req_ready, w_wdata_ready;
  act_t            w_act;
  logic [1:0]      w_act_adr;
  logic [7:0]      w_act_dat;
  logic            w_fail, w_nak;

  assign w_fail = r_sts[1] | r_sts[0];
  assign w_nak  = r_sts[2];

  always_comb begin
    w_state = r_state;  w_ret = r_ret;  w_step = r_step;
    w_cyc = r_cyc;  w_we = r_we;  w_adr = r_adr;  w_dat = r_dat;
    w_tmo = r_tmo;  w_cnt = r_cnt;  w_rnw = r_rnw;  w_addr = r_addr;
    w_sts = r_sts;  w_pstat = r_pstat;  w_reinit = r_reinit;
    w_done = 1'b0;  w_status = r_status;  w_rvalid = 1'b0;  w_rdata = r_rdata;
    w_req_ready = 1'b0;  w_wdata_ready = 1'b0;
    w_act = A_NONE;  w_act_adr = ADR_CSR;  w_act_dat = 8'h00;

    case (r_state)
      S_INIT: begin
        case (r_step)
          3'd0: begin w_act = A_WR; w_act_adr = ADR_CSR;  w_act_dat = 8'hC0;    end
          3'd1: begin w_act = A_WR; w_act_adr = ADR_DPR;  w_act_dat = BUS_ID;   end
          3'd2: begin w_act = A_WR; w_act_adr = ADR_CMDR; w_act_dat = C_SETBUS; end
          3'd3: w_act = A_IRQ;
          3'd4: begin w_act = A_RD; w_act_adr = ADR_CMDR; end
          default: begin w_state = S_IDLE; w_step = '0; w_reinit = 1'b0; end
        endcase
      end
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (req_valid_i) begin
          w_rnw = req_rnw_i;  w_addr = req_addr_i;  w_cnt = req_len_i;
          w_pstat = ST_OK;  w_state = S_START;  w_step = '0;
        end
      end
      S_START: begin
        case (r_step)
          3'd0: begin w_act = A_WR; w_act_adr = ADR_CMDR; w_act_dat = C_START; end
          3'd1: w_act = A_IRQ;
          3'd2: begin w_act = A_RD; w_act_adr = ADR_CMDR; end
          default: begin
            w_step = '0;
            if (w_fail) begin w_pstat = ST_ERR; w_state = S_DONE; end
            else w_state = S_ADDR;
          end
        endcase
      end
      S_ADDR: begin
        case (r_step)
          3'd0: begin w_act = A_WR; w_act_adr = ADR_DPR;  w_act_dat = {r_addr, r_rnw}; end
          3'd1: begin w_act = A_WR; w_act_adr = ADR_CMDR; w_act_dat = C_WRITE; end
          3'd2: w_act = A_IRQ;
          3'd3: begin w_act = A_RD; w_act_adr = ADR_CMDR; end
          default: begin
            w_step = '0;
            if (w_fail)            begin w_pstat = ST_ERR; w_state = S_DONE; end
            else if (w_nak)        begin w_pstat = ST_NAK; w_state = S_STOP; end
            else if (r_cnt == '0)  w_state = S_STOP;
            else                   w_state = r_rnw ? S_RDATA : S_WDATA;
          end
        endcase
      end
      S_WDATA: begin
        case (r_step)
          3'd0: begin
            w_wdata_ready = 1'b1;
            if (wdata_valid_i) begin w_act = A_WR; w_act_adr = ADR_DPR; w_act_dat = wdata_i; end
          end
          3'd1: begin w_act = A_WR; w_act_adr = ADR_CMDR; w_act_dat = C_WRITE; end
          3'd2: w_act = A_IRQ;
          3'd3: begin w_act = A_RD; w_act_adr = ADR_CMDR; end
          default: begin
            w_step = '0;
            if (w_fail)      begin w_pstat = ST_ERR; w_state = S_DONE; end
            else if (w_nak)  begin w_pstat = ST_NAK; w_state = S_STOP; end
            else begin
              w_cnt = r_cnt - 6'd1;
              if (r_cnt == 6'd1) w_state = S_STOP;
            end
          end
        endcase
      end
      S_RDATA: begin
        case (r_step)
          3'd0: begin
            w_act = A_WR;  w_act_adr = ADR_CMDR;
            w_act_dat = (r_cnt == 6'd1) ? C_RDNAK : C_RDACK;
          end
          3'd1: w_act = A_IRQ;
          3'd2: begin w_act = A_RD; w_act_adr = ADR_CMDR; end
          3'd3: begin
            if (w_fail) begin w_pstat = ST_ERR; w_state = S_DONE; w_step = '0; end
            else begin w_act = A_RD; w_act_adr = ADR_DPR; end
          end
          default: begin
            w_step = '0;
            w_cnt = r_cnt - 6'd1;
            if (r_cnt == 6'd1) w_state = S_STOP;
          end
        endcase
      end
      S_STOP: begin
        case (r_step)
          3'd0: begin w_act = A_WR; w_act_adr = ADR_CMDR; w_act_dat = C_STOP; end
          3'd1: w_act = A_IRQ;
          3'd2: begin w_act = A_RD; w_act_adr = ADR_CMDR; end
          default: begin
            w_step = '0;
            if (w_fail) w_pstat = ST_ERR;
            w_state = S_DONE;
          end
        endcase
      end
      S_DONE: begin
        w_done = 1'b1;  w_status = r_pstat;  w_step = '0;
        w_state = r_reinit ? S_INIT : S_IDLE;
      end
      S_WB_ACC: begin
        if (ack_i) begin
          w_cyc = 1'b0;  w_state = r_ret;
          if (!r_we && r_adr == ADR_CMDR) w_sts = dat_i[6:4];
          if (!r_we && r_adr == ADR_DPR && r_ret == S_RDATA) begin
            w_rvalid = 1'b1;  w_rdata = dat_i;
          end
        end
      end
      S_IRQ_WAIT: begin
        if (irq_i) w_state = r_ret;
        else if (r_tmo == TMO_LAST) begin
          // A hung init has no requester to report to, so it just starts over.
          w_step = '0;
          if (r_ret == S_INIT) w_state = S_INIT;
          else begin w_pstat = ST_TMO; w_reinit = 1'b1; w_state = S_DONE; end
        end else w_tmo = r_tmo + TW'(1);
      end
      default: begin w_state = S_INIT; w_step = '0; end
    endcase

    case (w_act)
      A_WR, A_RD: begin
        w_ret = r_state;  w_state = S_WB_ACC;  w_step = r_step + 3'd1;
        w_cyc = 1'b1;  w_we = (w_act == A_WR);  w_adr = w_act_adr;  w_dat = w_act_dat;
      end
      A_IRQ: begin
        w_ret = r_state;  w_state = S_IRQ_WAIT;  w_step = r_step + 3'd1;  w_tmo = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_INIT;  r_ret <= S_INIT;  r_step <= '0;
      r_cyc <= 1'b0;  r_we <= 1'b0;  r_adr <= '0;  r_dat <= '0;
      r_tmo <= '0;  r_cnt <= '0;  r_rnw <= 1'b0;  r_addr <= '0;
      r_sts <= '0;  r_pstat <= ST_OK;  r_reinit <= 1'b0;
      r_done <= 1'b0;  r_status <= ST_OK;  r_rvalid <= 1'b0;  r_rdata <= '0;
    end else begin
      r_state <= w_state;  r_ret <= w_ret;  r_step <= w_step;
      r_cyc <= w_cyc;  r_we <= w_we;  r_adr <= w_adr;  r_dat <= w_dat;
      r_tmo <= w_tmo;  r_cnt <= w_cnt;  r_rnw <= w_rnw;  r_addr <= w_addr;
      r_sts <= w_sts;  r_pstat <= w_pstat;  r_reinit <= w_reinit;
      r_done <= w_done;  r_status <= w_status;  r_rvalid <= w_rvalid;  r_rdata <= w_rdata;
    end
  end

  assign req_ready_o   = w_req_ready;
  assign wdata_ready_o = w_wdata_ready;
  assign busy_o        = (r_state != S_IDLE);
  assign rdata_valid_o = r_rvalid;
  assign rdata_o       = r_rdata;
  assign done_o        = r_done;
  assign status_o      = r_status;
  assign cyc_o         = r_cyc;
  assign stb_o         = r_cyc;
  assign we_o          = r_we;
  assign adr_o         = r_adr;
  assign dat_o         = r_dat;
endmodule

// File: tb/tb_iicmb_cmd_sequencer.sv
// Bench for iicmb_cmd_sequencer: IICMB/Wishbone slave model, transaction-level
// expectation queues and a per-cycle checker.
module tb_iicmb_cmd_sequencer;
  localparam logic [7:0] BUS = 8'h00;
  localparam int IRQ_TO = 40;

  logic clk_i, rst_n_i;
  logic req_valid_i, req_ready_o, req_rnw_i;
  logic [6:0] req_addr_i;
  logic [5:0] req_len_i;
  logic wdata_valid_i, wdata_ready_o;
  logic [7:0] wdata_i, rdata_o, dat_o, dat_i;
  logic rdata_valid_o, done_o, busy_o, cyc_o, stb_o, we_o, ack_i, irq_i;
  logic [1:0] status_o, adr_o;

  iicmb_cmd_sequencer #(.BUS_ID(BUS), .IRQ_TIMEOUT(IRQ_TO)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_rnw_i(req_rnw_i),
    .req_addr_i(req_addr_i), .req_len_i(req_len_i),
    .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i),
    .rdata_valid_o(rdata_valid_o), .rdata_o(rdata_o),
    .done_o(done_o), .status_o(status_o), .busy_o(busy_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i));

  initial begin clk_i = 1'b0; forever #5 clk_i = ~clk_i; end
  initial begin #1000000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin bad++; $display("FAIL %s: got 'h%0h want 'h%0h", nm, act, exp); end
  endtask
  task automatic fail(input string nm);
    total++; bad++; $display("FAIL %s: unexpected event", nm);
  endtask

  // ---- transaction model: expected WB accesses {we,adr,dat}, read bytes, statuses
  logic [10:0] exp_q[$];
  logic [7:0]  exp_rd[$];
  logic [1:0]  exp_st[$];
  logic [7:0]  wd_q[$];

  function automatic logic [10:0] mw(input logic [1:0] a, input logic [7:0] d);
    return {1'b1, a, d};
  endfunction
  function automatic logic [10:0] mr(input logic [1:0] a);
    return {1'b0, a, 8'h00};
  endfunction
  task automatic m_step(input logic [7:0] c);
    exp_q.push_back(mw(2'd2, c)); exp_q.push_back(mr(2'd2));
  endtask
  task automatic m_init();
    exp_q.push_back(mw(2'd0, 8'hC0)); exp_q.push_back(mw(2'd1, BUS)); m_step(8'h06);
  endtask
  task automatic m_txn(input bit rnw, input logic [6:0] a, input int len, input bit nak);
    m_step(8'h04);
    exp_q.push_back(mw(2'd1, {a, rnw}));
    m_step(8'h01);
    if (nak) begin m_step(8'h05); exp_st.push_back(2'b01); return; end
    for (int i = 0; i < len; i++) begin
      if (rnw) begin
        m_step((i == len - 1) ? 8'h03 : 8'h02);
        exp_q.push_back(mr(2'd1));
        exp_rd.push_back(8'(100 + i));
      end else begin
        exp_q.push_back(mw(2'd1, wd_q[i])); m_step(8'h01);
      end
    end
    m_step(8'h05); exp_st.push_back(2'b00);
  endtask

  // ---- slave / environment state
  bit was_ack, p_cyc, sup_start, nak_addr, al_start, addr_pending, want_dpr;
  logic p_we; logic [1:0] p_adr; logic [7:0] p_dat;
  int lat = 0, irq_cnt = 0, acc_cnt = 0, rd_seen = 0, done_cnt = 0, wd_delay = 2;
  logic [7:0] rd_byte = 8'd100, cmdr_val = 8'h80, dpr_first = 8'h00;
  logic [1:0] last_st = 2'b00;
  time t_start = 0;

  task automatic wb_access();
    logic [10:0] e;
    acc_cnt++;
    if (exp_q.size() == 0) fail("wb_extra");
    else begin
      e = exp_q.pop_front();
      if (we_o) chk("wb_write", 32'({we_o, adr_o, dat_o}), 32'(e));
      else      chk("wb_read", 32'({we_o, adr_o}), 32'(e[10:8]));
    end
    if (we_o) begin
      if (adr_o == 2'd2) begin
        irq_cnt = 3;
        if (dat_o == 8'h04) begin
          addr_pending = 1; want_dpr = 1; t_start = $time;
          cmdr_val = al_start ? 8'h20 : 8'h80;
          if (sup_start) irq_cnt = 0;
        end else if (dat_o == 8'h01) begin
          cmdr_val = (addr_pending && nak_addr) ? 8'h40 : 8'h80; addr_pending = 0;
        end else cmdr_val = 8'h80;
      end else if (adr_o == 2'd1 && want_dpr) begin dpr_first = dat_o; want_dpr = 0; end
    end else begin
      if (adr_o == 2'd2)      begin dat_i = cmdr_val; irq_i = 1'b0; end
      else if (adr_o == 2'd1) begin dat_i = rd_byte; rd_byte++; end
      else dat_i = 8'h00;
    end
  endtask

  // Single compare/respond process, runs on every falling edge.
  initial begin : env
    forever begin
      @(negedge clk_i);
      was_ack = ack_i;
      ack_i = 1'b0; dat_i = 8'h00;
      if (wdata_valid_i) begin wdata_valid_i = 1'b0; if (wd_q.size() > 0) void'(wd_q.pop_front()); end
      if (!rst_n_i) begin
        p_cyc = 0; last_st = 2'b00; lat = 0;
      end else begin
        chk("stb_eq_cyc", 32'(stb_o), 32'(cyc_o));
        if (was_ack) chk("idle_after_ack", 32'(cyc_o), 32'(0));
        else if (p_cyc && cyc_o) chk("wb_stable", 32'({we_o, adr_o, dat_o}), 32'({p_we, p_adr, p_dat}));
        if (wdata_ready_o) chk("no_wb_while_wait_data", 32'(cyc_o), 32'(0));
        if (rdata_valid_o) begin
          rd_seen++;
          if (exp_rd.size() == 0) fail("rdata_extra");
          else chk("rdata", 32'(rdata_o), 32'(exp_rd.pop_front()));
        end
        if (done_o) begin
          done_cnt++;
          if (exp_st.size() == 0) fail("done_extra");
          else begin last_st = exp_st.pop_front(); chk("status", 32'(status_o), 32'(last_st)); end
        end else chk("status_hold", 32'(status_o), 32'(last_st));
        if (irq_cnt > 0) begin irq_cnt--; if (irq_cnt == 0) irq_i = 1'b1; end
        if (cyc_o && !was_ack) begin
          if (lat > 0) lat--;
          else begin ack_i = 1'b1; wb_access(); lat = acc_cnt % 3; end
        end
        if (wdata_ready_o && wd_q.size() > 0) begin
          if (wd_delay > 0) wd_delay--;
          else begin wdata_valid_i = 1'b1; wdata_i = wd_q[0]; wd_delay = 2; end
        end
      end
      p_cyc = cyc_o; p_we = we_o; p_adr = adr_o; p_dat = dat_o;
    end
  end

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!req_ready_o && n < budget) begin @(negedge clk_i); n++; end
    chk("ready_within_budget", 32'(req_ready_o), 32'(1));
  endtask
  task automatic wait_done(input int budget);
    int n = 0;
    do begin @(negedge clk_i); n++; end while (!done_o && n < budget);
    chk("done_within_budget", 32'(done_o), 32'(1));
  endtask
  task automatic send_req(input logic rnw, input logic [6:0] a, input logic [5:0] len);
    wait_ready(50);
    req_valid_i = 1'b1; req_rnw_i = rnw; req_addr_i = a; req_len_i = len;
    @(negedge clk_i);
    req_valid_i = 1'b0; req_rnw_i = ~rnw; req_addr_i = 7'h7F; req_len_i = 6'h3F;
    chk("ready_drop", 32'(req_ready_o), 32'(0));
    chk("busy_set", 32'(busy_o), 32'(1));
  endtask
  task automatic drained();
    chk("wb_q_drained", 32'(exp_q.size()), 32'(0));
    chk("rd_q_drained", 32'(exp_rd.size()), 32'(0));
    chk("st_q_drained", 32'(exp_st.size()), 32'(0));
  endtask

  initial begin : main
    int dc;
    rst_n_i = 1'b0; req_valid_i = 0; req_rnw_i = 0; req_addr_i = '0; req_len_i = '0;
    wdata_valid_i = 0; wdata_i = '0; dat_i = '0; ack_i = 0; irq_i = 0;
    repeat (2) @(negedge clk_i);
    chk("rst_wb", 32'({cyc_o, stb_o, we_o, adr_o, dat_o}), 32'(0));
    chk("rst_hs", 32'({req_ready_o, wdata_ready_o, rdata_valid_o, rdata_o, done_o}), 32'(0));
    chk("rst_status", 32'(status_o), 32'(0));
    chk("rst_busy", 32'(busy_o), 32'(1));

    // init after reset
    m_init(); rst_n_i = 1'b1;
    wait_ready(300);
    chk("init_acc_cnt", 32'(acc_cnt), 32'd4);
    chk("idle_not_busy", 32'(busy_o), 32'(0));
    drained();

    // write 0x22, 2 bytes
    acc_cnt = 0; wd_q = '{8'h00, 8'h01}; m_txn(1'b0, 7'h22, 2, 1'b0);
    send_req(1'b0, 7'h22, 6'd2); wait_done(1000);
    chk("wr_status_lit", 32'(status_o), 32'd0);
    chk("wr_dpr_lit", 32'(dpr_first), 32'h44);
    wait_ready(10); chk("wr_acc_lit", 32'(acc_cnt), 32'd13); drained();

    // read 0x22, 32 bytes
    acc_cnt = 0; rd_seen = 0; rd_byte = 8'd100; m_txn(1'b1, 7'h22, 32, 1'b0);
    send_req(1'b1, 7'h22, 6'd32); wait_done(5000);
    chk("rd_status_lit", 32'(status_o), 32'd0);
    chk("rd_dpr_lit", 32'(dpr_first), 32'h45);
    chk("rd_pulses_lit", 32'(rd_seen), 32'd32);
    wait_ready(10); chk("rd_acc_lit", 32'(acc_cnt), 32'd103); drained();

    // address NAK on a 3-byte read
    acc_cnt = 0; rd_seen = 0; nak_addr = 1; m_txn(1'b1, 7'h22, 3, 1'b1);
    send_req(1'b1, 7'h22, 6'd3); wait_done(1000);
    chk("nak_status_lit", 32'(status_o), 32'd1);
    chk("nak_no_rdata", 32'(rd_seen), 32'd0);
    wait_ready(10); chk("nak_acc_lit", 32'(acc_cnt), 32'd7); drained(); nak_addr = 0;

    // zero-length write
    acc_cnt = 0; m_txn(1'b0, 7'h22, 0, 1'b0);
    send_req(1'b0, 7'h22, 6'd0); wait_done(1000);
    wait_ready(10); chk("len0_acc_lit", 32'(acc_cnt), 32'd7); drained();

    // arbitration lost on Start: no Stop
    acc_cnt = 0; al_start = 1; m_step(8'h04); exp_st.push_back(2'b10);
    send_req(1'b0, 7'h10, 6'd1); wait_done(500);
    chk("al_status_lit", 32'(status_o), 32'd2);
    wait_ready(10); chk("al_acc_lit", 32'(acc_cnt), 32'd2); drained(); al_start = 0;

    // irq never arrives after Start: timeout then re-init
    acc_cnt = 0; sup_start = 1;
    exp_q.push_back(mw(2'd2, 8'h04)); exp_st.push_back(2'b11); m_init();
    send_req(1'b1, 7'h22, 6'd4); wait_done(500);
    dc = int'(($time - t_start) / 10);
    chk("tmo_latency", 32'(dc >= IRQ_TO && dc <= IRQ_TO + 6), 32'(1));
    chk("tmo_status_lit", 32'(status_o), 32'd3);
    sup_start = 0;
    wait_ready(300); chk("tmo_acc_lit", 32'(acc_cnt), 32'd5); drained();

    // reset during the first data byte write
    wd_q = '{8'hA5, 8'h5A}; m_txn(1'b0, 7'h22, 2, 1'b0);
    send_req(1'b0, 7'h22, 6'd2);
    dc = 0;
    while (!(cyc_o && we_o && adr_o == 2'd1 && dat_o == 8'hA5) && dc < 200) begin
      @(negedge clk_i); dc++;
    end
    chk("reached_data_byte", 32'(cyc_o && we_o && dat_o == 8'hA5), 32'(1));
    #2 rst_n_i = 1'b0;
    #1 chk("rst_mid_cyc_stb", 32'({cyc_o, stb_o}), 32'(0));
    exp_q.delete(); exp_rd.delete(); exp_st.delete(); wd_q.delete();
    wdata_valid_i = 1'b0; irq_cnt = 0; irq_i = 1'b0;
    dc = done_cnt;
    repeat (3) @(negedge clk_i);
    chk("rst_mid_busy", 32'({busy_o, req_ready_o}), 32'b10);
    m_init(); acc_cnt = 0; rst_n_i = 1'b1;
    wait_ready(300);
    chk("rst_mid_no_done", 32'(done_cnt), 32'(dc));
    chk("rst_mid_reinit_acc", 32'(acc_cnt), 32'd4); drained();

    repeat (3) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
